// File: rtl/bus_master_arbiter.sv
// Four-master round-robin bus arbiter with active-low requests/grants and registered outputs.
// Optional owner hold limit under macro BUS_ARB_HOLD_LIMIT_EN (MAX_HOLD cycles while others wait).
module bus_master_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  input  logic       m0_busy,
  input  logic       m1_busy,
  input  logic       m2_busy,
  input  logic       m3_busy,
  input  logic       m_rdy_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output logic [1:0] owner,
  output logic       bus_active
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q;
  logic [3:0] grnt_q;
  logic [1:0] owner_q;
  logic [1:0] last_q;
  logic       bus_active_q;

  logic [3:0] req;
  logic [3:0] busy;
  logic [3:0] others_req;
  logic       own_req;
  logic       own_busy;
  logic       release_d;
  logic       force_d;
  logic       idle_found;
  logic [1:0] idle_idx;
  logic       rel_found;
  logic [1:0] rel_idx;

  // First requester at or after start, wrapping 3 -> 0.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = start + 2'(i);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign req  = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign busy = {m3_busy, m2_busy, m1_busy, m0_busy};

`ifdef BUS_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_q;
  assign force_d = (hold_q == 8'(MAX_HOLD)) && !m_rdy_;
`else
  logic [8:0] unused_cfg;
  assign unused_cfg = {m_rdy_, 8'(MAX_HOLD)};
  assign force_d    = 1'b0;
`endif

  always_comb begin
    own_req    = req[owner_q];
    own_busy   = busy[owner_q];
    others_req = req & ~(4'b0001 << owner_q);
    release_d  = (!own_req && !own_busy) || force_d;
    {idle_found, idle_idx} = rr_pick(req, last_q + 2'd1);
    // Searching from owner+1 puts the releasing owner's own re-request last.
    {rel_found, rel_idx}   = rr_pick(req, owner_q + 2'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grnt_q       <= 4'hF;
      owner_q      <= 2'd0;
      last_q       <= 2'd3;
      bus_active_q <= 1'b0;
`ifdef BUS_ARB_HOLD_LIMIT_EN
      hold_q       <= 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_found) begin
            state_q      <= GRANT;
            grnt_q       <= ~(4'b0001 << idle_idx);
            owner_q      <= idle_idx;
            last_q       <= idle_idx;
            bus_active_q <= 1'b1;
          end
`ifdef BUS_ARB_HOLD_LIMIT_EN
          hold_q <= 8'd0;
`endif
        end
        GRANT: begin
          if (release_d) begin
            if (rel_found) begin
              grnt_q  <= ~(4'b0001 << rel_idx);
              owner_q <= rel_idx;
              last_q  <= rel_idx;
            end else begin
              state_q      <= IDLE;
              grnt_q       <= 4'hF;
              bus_active_q <= 1'b0;
            end
`ifdef BUS_ARB_HOLD_LIMIT_EN
            hold_q <= 8'd0;
`endif
          end
`ifdef BUS_ARB_HOLD_LIMIT_EN
          else if (|others_req && hold_q != 8'(MAX_HOLD)) begin
            hold_q <= hold_q + 8'd1;
          end
`endif
        end
        default: begin
          state_q      <= IDLE;
          grnt_q       <= 4'hF;
          bus_active_q <= 1'b0;
        end
      endcase
    end
  end

`ifndef BUS_ARB_HOLD_LIMIT_EN
  logic [3:0] unused_others;
  assign unused_others = others_req;
`endif

  assign {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} = grnt_q;
  assign owner      = owner_q;
  assign bus_active = bus_active_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed-vector scoreboard bench for bus_master_arbiter; expectations queued per cycle, checked by a monitor.
module tb_bus_master_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       m0_req_, m1_req_, m2_req_, m3_req_;
  logic       m0_busy, m1_busy, m2_busy, m3_busy;
  logic       m_rdy_;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic       bus_active;

  typedef struct {
    logic [3:0] g;
    logic [1:0] o;
    logic       a;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [3:0] GN = 4'hF;
  localparam logic [3:0] G0 = 4'b1110;
  localparam logic [3:0] G1 = 4'b1101;
  localparam logic [3:0] G2 = 4'b1011;
  localparam logic [3:0] G3 = 4'b0111;

  bus_master_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(m0_req_), .m1_req_(m1_req_), .m2_req_(m2_req_), .m3_req_(m3_req_),
    .m0_busy(m0_busy), .m1_busy(m1_busy), .m2_busy(m2_busy), .m3_busy(m3_busy),
    .m_rdy_(m_rdy_),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
    .owner(owner), .bus_active(bus_active)
  );

  always #5 clk = ~clk;

  // rq/bz are active-high masks {m3,m2,m1,m0}; expectation is for outputs after the next edge.
  task automatic cyc(input logic [3:0] rq, input logic [3:0] bz, input logic rdy_n,
                     input logic rst, input logic [3:0] eg, input logic [1:0] eo,
                     input logic ea, input string tag);
    exp_t e;
    reset = rst;
    {m3_req_, m2_req_, m1_req_, m0_req_} = ~rq;
    {m3_busy, m2_busy, m1_busy, m0_busy} = bz;
    m_rdy_ = rdy_n;
    e.g = eg; e.o = eo; e.a = ea; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if ({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_} !== e.g || owner !== e.o || bus_active !== e.a) begin
        errors++;
        $display("FAIL %s: got grnt_=%b owner=%0d active=%b, want grnt_=%b owner=%0d active=%b",
                 e.tag, {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}, owner, bus_active, e.g, e.o, e.a);
      end
    end
  end

  initial begin
    reset = 1'b1;
    {m3_req_, m2_req_, m1_req_, m0_req_} = 4'hF;
    {m3_busy, m2_busy, m1_busy, m0_busy} = 4'h0;
    m_rdy_ = 1'b1;
    @(negedge clk);

    // T1: reset with all requesting, then m0 wins first
    for (int i = 0; i < 3; i++) cyc(4'hF, 4'h0, 1'b1, 1'b1, GN, 2'd0, 1'b0, "t1_reset");
    cyc(4'hF, 4'h0, 1'b1, 1'b0, G0, 2'd0, 1'b1, "t1_first_grant");
    cyc(4'h0, 4'h0, 1'b1, 1'b0, GN, 2'd0, 1'b0, "t1_release_idle");

    // T2: single request from m1
    cyc(4'h2, 4'h0, 1'b1, 1'b0, G1, 2'd1, 1'b1, "t2_grant_m1");
    cyc(4'h2, 4'h0, 1'b1, 1'b0, G1, 2'd1, 1'b1, "t2_hold_m1");
    cyc(4'h2, 4'h0, 1'b1, 1'b0, G1, 2'd1, 1'b1, "t2_hold_m1");
    cyc(4'h0, 4'h0, 1'b1, 1'b0, GN, 2'd1, 1'b0, "t2_release");

    // T3: rotation 0,1,2,3,0 with no bubble
    cyc(4'h0, 4'h0, 1'b1, 1'b1, GN, 2'd0, 1'b0, "t3_reset");
    cyc(4'hF, 4'h0, 1'b1, 1'b0, G0, 2'd0, 1'b1, "t3_rot0");
    cyc(4'hF, 4'h0, 1'b1, 1'b0, G0, 2'd0, 1'b1, "t3_rot0_hold");
    cyc(4'hE, 4'h0, 1'b1, 1'b0, G1, 2'd1, 1'b1, "t3_rot1");
    cyc(4'hF, 4'h0, 1'b1, 1'b0, G1, 2'd1, 1'b1, "t3_rot1_hold");
    cyc(4'hD, 4'h0, 1'b1, 1'b0, G2, 2'd2, 1'b1, "t3_rot2");
    cyc(4'hF, 4'h0, 1'b1, 1'b0, G2, 2'd2, 1'b1, "t3_rot2_hold");
    cyc(4'hB, 4'h0, 1'b1, 1'b0, G3, 2'd3, 1'b1, "t3_rot3");
    cyc(4'hF, 4'h0, 1'b1, 1'b0, G3, 2'd3, 1'b1, "t3_rot3_hold");
    cyc(4'h7, 4'h0, 1'b1, 1'b0, G0, 2'd0, 1'b1, "t3_wrap0");
    cyc(4'h0, 4'h0, 1'b1, 1'b0, GN, 2'd0, 1'b0, "t3_idle");

    // T4: busy holds m1 while m0 waits; non-owner busy ignored
    cyc(4'h2, 4'h0, 1'b1, 1'b0, G1, 2'd1, 1'b1, "t4_grant_m1");
    for (int i = 0; i < 3; i++) cyc(4'h1, 4'h2, 1'b1, 1'b0, G1, 2'd1, 1'b1, "t4_busy_hold");
    cyc(4'h1, 4'h0, 1'b1, 1'b0, G0, 2'd0, 1'b1, "t4_handoff_m0");
    cyc(4'h0, 4'h4, 1'b1, 1'b0, GN, 2'd0, 1'b0, "t4_nonowner_busy");

    // T5: m0 holds while m2 waits, m_rdy_ low
    cyc(4'h1, 4'h0, 1'b0, 1'b0, G0, 2'd0, 1'b1, "t5_grant_m0");
`ifdef BUS_ARB_HOLD_LIMIT_EN
    for (int i = 0; i < 4; i++) cyc(4'h5, 4'h0, 1'b0, 1'b0, G0, 2'd0, 1'b1, "t5_count");
    cyc(4'h5, 4'h0, 1'b0, 1'b0, G2, 2'd2, 1'b1, "t5_forced_m2");
`else
    for (int i = 0; i < 50; i++) cyc(4'h5, 4'h0, 1'b0, 1'b0, G0, 2'd0, 1'b1, "t5_no_limit");
    cyc(4'h4, 4'h0, 1'b0, 1'b0, G2, 2'd2, 1'b1, "t5_handoff_m2");
`endif
    cyc(4'h0, 4'h0, 1'b1, 1'b0, GN, 2'd2, 1'b0, "t5_idle");

    // T6: reset while m3 owns a busy transfer
    cyc(4'h8, 4'h0, 1'b1, 1'b0, G3, 2'd3, 1'b1, "t6_grant_m3");
    cyc(4'h0, 4'h8, 1'b1, 1'b0, G3, 2'd3, 1'b1, "t6_busy_m3");
    cyc(4'h0, 4'h8, 1'b1, 1'b1, GN, 2'd0, 1'b0, "t6_reset_mid");
    cyc(4'hF, 4'h0, 1'b1, 1'b0, G0, 2'd0, 1'b1, "t6_after0");
    cyc(4'hE, 4'h0, 1'b1, 1'b0, G1, 2'd1, 1'b1, "t6_after1");
    cyc(4'hC, 4'h0, 1'b1, 1'b0, G2, 2'd2, 1'b1, "t6_after2");
    cyc(4'h8, 4'h0, 1'b1, 1'b0, G3, 2'd3, 1'b1, "t6_after3");
    cyc(4'h0, 4'h0, 1'b1, 1'b0, GN, 2'd3, 1'b0, "t6_idle");

    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
